// File: rtl/smvm_pkg.sv
// Shared constants for the SMVM stream transmitter: widths, state codes,
// nonzero-word field offsets and the start-configuration check.
package smvm_pkg;

    localparam int DW      = 8;
    localparam int VEC_MAX = 128;

    localparam int VAL_LSB = 0;
    localparam int COL_LSB = DW;
    localparam int IPV_BIT = 2*DW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_VEC  = 3'd3;
    localparam logic [2:0] S_MAT  = 3'd4;
    localparam logic [2:0] S_TERM = 3'd5;

    function automatic logic cfg_ok(input logic [DW-1:0] r, input logic [DW-1:0] c);
        return (r != '0) && (c != '0) && (32'(c) <= VEC_MAX);
    endfunction

endpackage

// File: rtl/smvm_stream_tx.sv
// SMVM input-stream producer: header, dense vector, nonzero entries, terminator.
// Define SMVM_TX_COLCHK_EN to flag nonzero entries whose column is >= cols.
module smvm_stream_tx
    import smvm_pkg::*;
#(
    parameter int VEC_AW = 7,
    parameter int NZ_AW  = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DW-1:0]       rows,
    input  logic [DW-1:0]       cols,
    input  logic [NZ_AW:0]      nnz,
    output logic                busy,
    output logic                done,
    output logic                err_cfg,
    output logic                err_zero,
    output logic                err_col,
    output logic                vec_rd,
    output logic [VEC_AW-1:0]   vec_addr,
    input  logic [DW-1:0]       vec_rdata,
    output logic                nz_rd,
    output logic [NZ_AW-1:0]    nz_addr,
    input  logic [2*DW:0]       nz_rdata,
    output logic [DW-1:0]       val_out,
    output logic [DW-1:0]       col_out,
    output logic                ipv_out
);

    logic [2:0]       state;
    logic [DW-1:0]    rows_q;
    logic [DW-1:0]    cols_q;
    logic [NZ_AW:0]   nnz_q;
    logic [NZ_AW-1:0] rd_cnt;
    logic [NZ_AW-1:0] beat_cnt;

    logic          vec_last_rd;
    logic          nz_last_rd;
    logic          vec_last_beat;
    logic          nz_last_beat;
    logic          load_nz;
    logic [DW-1:0] nz_val;
    logic [DW-1:0] nz_col;
    logic          nz_ipv;

    assign nz_val = nz_rdata[VAL_LSB +: DW];
    assign nz_col = nz_rdata[COL_LSB +: DW];
    assign nz_ipv = nz_rdata[IPV_BIT];

    // One address counter serves both buffers; it restarts at the vector/nonzero handover.
    assign vec_addr = vec_rd ? rd_cnt[VEC_AW-1:0] : '0;
    assign nz_addr  = nz_rd  ? rd_cnt : '0;

    assign vec_last_rd   = (rd_cnt == NZ_AW'(cols_q - DW'(1)));
    assign nz_last_rd    = ({1'b0, rd_cnt} == nnz_q - (NZ_AW+1)'(1));
    assign vec_last_beat = (beat_cnt == NZ_AW'(cols_q - DW'(1)));
    assign nz_last_beat  = ({1'b0, beat_cnt} == nnz_q - (NZ_AW+1)'(1));

    always_comb begin
        load_nz = 1'b0;
        if (state == S_VEC && vec_last_beat && nnz_q != '0)
            load_nz = 1'b1;
        else if (state == S_MAT && !nz_last_beat)
            load_nz = 1'b1;
    end

`ifndef SMVM_TX_COLCHK_EN
    assign err_col = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            nnz_q    <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_cfg  <= 1'b0;
            err_zero <= 1'b0;
`ifdef SMVM_TX_COLCHK_EN
            err_col  <= 1'b0;
`endif
            vec_rd   <= 1'b0;
            nz_rd    <= 1'b0;
            val_out  <= '0;
            col_out  <= '0;
            ipv_out  <= 1'b0;
        end else begin
            err_cfg <= 1'b0;
            done    <= 1'b0;
            val_out <= '0;
            col_out <= '0;
            ipv_out <= 1'b0;

            if (vec_rd) begin
                if (vec_last_rd) begin
                    vec_rd <= 1'b0;
                    rd_cnt <= '0;
                    nz_rd  <= (nnz_q != '0);
                end else begin
                    rd_cnt <= rd_cnt + NZ_AW'(1);
                end
            end else if (nz_rd) begin
                if (nz_last_rd)
                    nz_rd <= 1'b0;
                else
                    rd_cnt <= rd_cnt + NZ_AW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok(rows, cols)) begin
                            state    <= S_PRE;
                            busy     <= 1'b1;
                            vec_rd   <= 1'b1;
                            rd_cnt   <= '0;
                            rows_q   <= rows;
                            cols_q   <= cols;
                            nnz_q    <= nnz;
                            err_zero <= 1'b0;
`ifdef SMVM_TX_COLCHK_EN
                            err_col  <= 1'b0;
`endif
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    state   <= S_HDR;
                    val_out <= rows_q;
                    col_out <= cols_q;
                end
                S_HDR: begin
                    state    <= S_VEC;
                    val_out  <= vec_rdata;
                    beat_cnt <= '0;
                end
                S_VEC: begin
                    if (vec_last_beat) begin
                        beat_cnt <= '0;
                        if (nnz_q == '0) begin
                            state <= S_TERM;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_MAT;
                        end
                    end else begin
                        val_out  <= vec_rdata;
                        col_out  <= DW'(beat_cnt + NZ_AW'(1));
                        beat_cnt <= beat_cnt + NZ_AW'(1);
                    end
                end
                S_MAT: begin
                    if (nz_last_beat) begin
                        state <= S_TERM;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + NZ_AW'(1);
                    end
                end
                S_TERM:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // A zero value becomes the terminator beat and cancels the read still in flight.
            if (load_nz) begin
                if (nz_val == '0) begin
                    state    <= S_TERM;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    nz_rd    <= 1'b0;
                    err_zero <= 1'b1;
                end else begin
                    val_out <= nz_val;
                    col_out <= nz_col;
                    ipv_out <= nz_ipv;
`ifdef SMVM_TX_COLCHK_EN
                    if (nz_col >= cols_q)
                        err_col <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed bench for smvm_stream_tx; traces each transfer cycle by cycle and
// compares against hand-written tables.
module tb_smvm_stream_tx;

    localparam int NC = 140;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   rows = '0;
    logic [7:0]   cols = '0;
    logic [12:0]  nnz = '0;
    logic         busy, done, err_cfg, err_zero, err_col;
    logic         vec_rd, nz_rd;
    logic [6:0]   vec_addr;
    logic [11:0]  nz_addr;
    logic [7:0]   vec_rdata = '0;
    logic [16:0]  nz_rdata = '0;
    logic [7:0]   val_out, col_out;
    logic         ipv_out;

    logic [7:0]   vec_mem [0:127];
    logic [16:0]  nz_mem  [0:15];

    logic [7:0]   t_val [0:NC-1];
    logic [7:0]   t_col [0:NC-1];
    logic         t_ipv [0:NC-1];
    logic         t_done [0:NC-1];
    logic         t_busy [0:NC-1];
    logic         t_vrd [0:NC-1];
    logic [6:0]   t_vaddr [0:NC-1];
    logic         t_nrd [0:NC-1];
    logic [11:0]  t_naddr [0:NC-1];
    logic         t_ecfg [0:NC-1];
    logic         t_ezero [0:NC-1];
    logic         t_ecol [0:NC-1];

    logic [18:0]  basic_exp [1:10];

    int total = 0;
    int bad = 0;

    smvm_stream_tx #(.VEC_AW(7), .NZ_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rows(rows), .cols(cols), .nnz(nnz),
        .busy(busy), .done(done), .err_cfg(err_cfg), .err_zero(err_zero), .err_col(err_col),
        .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_rdata(vec_rdata),
        .nz_rd(nz_rd), .nz_addr(nz_addr), .nz_rdata(nz_rdata),
        .val_out(val_out), .col_out(col_out), .ipv_out(ipv_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vec_rd) vec_rdata <= vec_mem[vec_addr];
        if (nz_rd)  nz_rdata  <= nz_mem[nz_addr[3:0]];
    end

    // Launch in cycle 0 and record cycles 1..NC-1; optionally re-pulse start at restart_at.
    task automatic run(input logic [7:0] r, input logic [7:0] c, input logic [12:0] n,
                       input int restart_at);
        @(negedge clk);
        rows = r; cols = c; nnz = n; start = 1'b1;
        for (int k = 1; k < NC; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (k == restart_at) begin
                rows = 8'd0; cols = 8'd50; nnz = 13'd1;
            end
            t_val[k] = val_out;   t_col[k] = col_out;  t_ipv[k] = ipv_out;
            t_done[k] = done;     t_busy[k] = busy;
            t_vrd[k] = vec_rd;    t_vaddr[k] = vec_addr;
            t_nrd[k] = nz_rd;     t_naddr[k] = nz_addr;
            t_ecfg[k] = err_cfg;  t_ezero[k] = err_zero; t_ecol[k] = err_col;
        end
        start = 1'b0;
    endtask

    task automatic load_basic();
        vec_mem[0] = 8'd5; vec_mem[1] = 8'hFF; vec_mem[2] = 8'd7;
        nz_mem[0] = {1'b1, 8'd0, 8'd3};
        nz_mem[1] = {1'b0, 8'd2, 8'hFE};
        nz_mem[2] = {1'b1, 8'd1, 8'd4};
    endtask

    task automatic check_basic_trace(input string tag);
        for (int k = 1; k <= 10; k++) begin
            total++;
            if ({t_val[k], t_col[k], t_ipv[k], t_done[k], t_busy[k]} !== basic_exp[k]) begin
                bad++;
                $display("FAIL %s beat cyc%0d: got %h want %h", tag, k,
                         {t_val[k], t_col[k], t_ipv[k], t_done[k], t_busy[k]}, basic_exp[k]);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            total++;
            if (t_vrd[k] !== (k <= 3) || (k <= 3 && t_vaddr[k] !== 7'(k - 1))) begin
                bad++;
                $display("FAIL %s vec_rd cyc%0d: got rd=%0b addr=%0d want rd=%0b addr=%0d",
                         tag, k, t_vrd[k], t_vaddr[k], (k <= 3), k - 1);
            end
            total++;
            if (t_nrd[k] !== (k >= 4 && k <= 6) || (k >= 4 && k <= 6 && t_naddr[k] !== 12'(k - 4))) begin
                bad++;
                $display("FAIL %s nz_rd cyc%0d: got rd=%0b addr=%0d want rd=%0b addr=%0d",
                         tag, k, t_nrd[k], t_naddr[k], (k >= 4 && k <= 6), k - 4);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err_cfg, err_zero, err_col, vec_rd, nz_rd, val_out, col_out, ipv_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, err_cfg, err_zero, err_col, vec_rd, nz_rd, val_out, col_out, ipv_out});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, vec_rd, nz_rd, val_out, col_out, ipv_out} !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: got %h want 0",
                     {busy, done, vec_rd, nz_rd, val_out, col_out, ipv_out});
        end
    endtask

    task automatic test_basic();
        load_basic();
        run(8'd2, 8'd3, 13'd3, -1);
        check_basic_trace("basic");
        total++;
        if (t_ecfg[1] !== 1'b0 || t_ezero[9] !== 1'b0) begin
            bad++;
            $display("FAIL basic_errs: got cfg=%0b zero=%0b want 0 0", t_ecfg[1], t_ezero[9]);
        end
    endtask

    task automatic test_nnz0();
        logic [18:0] ex [1:6];
        ex = '{{8'd0, 8'd0, 3'b001}, {8'd1, 8'd1, 3'b001}, {8'd9, 8'd0, 3'b001},
               {8'd0, 8'd0, 3'b010}, {8'd0, 8'd0, 3'b000}, {8'd0, 8'd0, 3'b000}};
        vec_mem[0] = 8'd9;
        run(8'd1, 8'd1, 13'd0, -1);
        for (int k = 1; k <= 6; k++) begin
            total++;
            if ({t_val[k], t_col[k], t_ipv[k], t_done[k], t_busy[k]} !== ex[k]) begin
                bad++;
                $display("FAIL nnz0 beat cyc%0d: got %h want %h", k,
                         {t_val[k], t_col[k], t_ipv[k], t_done[k], t_busy[k]}, ex[k]);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (t_nrd[k] !== 1'b0 || t_vrd[k] !== (k == 1)) begin
                bad++;
                $display("FAIL nnz0 reads cyc%0d: got vrd=%0b nrd=%0b want vrd=%0b nrd=0",
                         k, t_vrd[k], t_nrd[k], (k == 1));
            end
        end
    endtask

    task automatic test_cfg_err();
        logic [7:0] rr [0:2];
        logic [7:0] cc [0:2];
        rr = '{8'd2, 8'd2, 8'd0};
        cc = '{8'd0, 8'd129, 8'd3};
        for (int t = 0; t < 3; t++) begin
            run(rr[t], cc[t], 13'd3, -1);
            total++;
            if (t_ecfg[1] !== 1'b1 || t_ecfg[2] !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err%0d pulse: got %0b%0b want 10", t, t_ecfg[1], t_ecfg[2]);
            end
            for (int k = 1; k <= 6; k++) begin
                total++;
                if ({t_busy[k], t_vrd[k], t_nrd[k], t_val[k], t_done[k]} !== '0) begin
                    bad++;
                    $display("FAIL cfg_err%0d idle cyc%0d: got busy=%0b vrd=%0b nrd=%0b val=%0d done=%0b want 0",
                             t, k, t_busy[k], t_vrd[k], t_nrd[k], t_val[k], t_done[k]);
                end
            end
        end
    endtask

    task automatic test_cols_max();
        for (int j = 0; j < 128; j++) vec_mem[j] = 8'(j + 1);
        run(8'd4, 8'd128, 13'd0, -1);
        total++;
        if ({t_val[2], t_col[2]} !== {8'd4, 8'd128}) begin
            bad++;
            $display("FAIL colsmax_hdr: got %0d/%0d want 4/128", t_val[2], t_col[2]);
        end
        total++;
        if (t_vrd[128] !== 1'b1 || t_vaddr[128] !== 7'd127 || t_vrd[129] !== 1'b0) begin
            bad++;
            $display("FAIL colsmax_lastrd: got rd=%0b addr=%0d next=%0b want 1 127 0",
                     t_vrd[128], t_vaddr[128], t_vrd[129]);
        end
        total++;
        if ({t_val[130], t_col[130], t_done[130]} !== {8'd128, 8'd127, 1'b0}) begin
            bad++;
            $display("FAIL colsmax_lastbeat: got %0d/%0d d=%0b want 128/127 d=0",
                     t_val[130], t_col[130], t_done[130]);
        end
        total++;
        if ({t_val[131], t_done[131], t_busy[131]} !== {8'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL colsmax_term: got val=%0d done=%0b busy=%0b want 0 1 0",
                     t_val[131], t_done[131], t_busy[131]);
        end
    endtask

    task automatic test_zero_entry();
        logic [18:0] ex [1:7];
        ex = '{{8'd0, 8'd0, 3'b001}, {8'd3, 8'd2, 3'b001}, {8'd1, 8'd0, 3'b001},
               {8'd2, 8'd1, 3'b001}, {8'd6, 8'd1, 3'b101}, {8'd0, 8'd0, 3'b010},
               {8'd0, 8'd0, 3'b000}};
        vec_mem[0] = 8'd1; vec_mem[1] = 8'd2;
        nz_mem[0] = {1'b1, 8'd1, 8'd6};
        nz_mem[1] = {1'b1, 8'd1, 8'd0};
        nz_mem[2] = {1'b0, 8'd0, 8'd5};
        nz_mem[3] = {1'b0, 8'd0, 8'd9};
        run(8'd3, 8'd2, 13'd4, -1);
        for (int k = 1; k <= 7; k++) begin
            total++;
            if ({t_val[k], t_col[k], t_ipv[k], t_done[k], t_busy[k]} !== ex[k]) begin
                bad++;
                $display("FAIL zero beat cyc%0d: got %h want %h", k,
                         {t_val[k], t_col[k], t_ipv[k], t_done[k], t_busy[k]}, ex[k]);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            total++;
            if (t_nrd[k] !== (k >= 3 && k <= 5) || (k >= 3 && k <= 5 && t_naddr[k] !== 12'(k - 3))) begin
                bad++;
                $display("FAIL zero nz_rd cyc%0d: got rd=%0b addr=%0d want rd=%0b addr=%0d",
                         k, t_nrd[k], t_naddr[k], (k >= 3 && k <= 5), k - 3);
            end
        end
        total++;
        if (t_ezero[5] !== 1'b0 || t_ezero[6] !== 1'b1 || t_ezero[20] !== 1'b1) begin
            bad++;
            $display("FAIL zero_sticky: got %0b%0b%0b want 011", t_ezero[5], t_ezero[6], t_ezero[20]);
        end
        load_basic();
        run(8'd2, 8'd3, 13'd3, -1);
        total++;
        if (t_ezero[1] !== 1'b0) begin
            bad++;
            $display("FAIL zero_clear: got %0b want 0", t_ezero[1]);
        end
        check_basic_trace("after_zero");
    endtask

    task automatic test_restart_ignored();
        load_basic();
        run(8'd2, 8'd3, 13'd3, 4);
        check_basic_trace("restart");
        total++;
        if (t_ecfg[5] !== 1'b0) begin
            bad++;
            $display("FAIL restart_errcfg: got %0b want 0", t_ecfg[5]);
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        @(negedge clk);
        rows = 8'd2; cols = 8'd3; nnz = 13'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (val_out !== 8'hFE) begin
            bad++;
            $display("FAIL rstmid_precheck: got %h want fe", val_out);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({val_out, col_out, ipv_out, busy, nz_rd} !== '0) begin
            bad++;
            $display("FAIL rstmid_async: got %h want 0", {val_out, col_out, ipv_out, busy, nz_rd});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(8'd2, 8'd3, 13'd3, -1);
        check_basic_trace("after_rst");
    endtask

    task automatic test_colchk();
        logic exp_col;
`ifdef SMVM_TX_COLCHK_EN
        exp_col = 1'b1;
`else
        exp_col = 1'b0;
`endif
        vec_mem[0] = 8'd1; vec_mem[1] = 8'd2; vec_mem[2] = 8'd3; vec_mem[3] = 8'd4;
        nz_mem[0] = {1'b1, 8'd4, 8'd3};
        run(8'd1, 8'd4, 13'd1, -1);
        total++;
        if ({t_val[7], t_col[7], t_ipv[7]} !== {8'd3, 8'd4, 1'b1}) begin
            bad++;
            $display("FAIL colchk_beat: got %0d/%0d/%0b want 3/4/1", t_val[7], t_col[7], t_ipv[7]);
        end
        total++;
        if (t_done[8] !== 1'b1 || t_ecol[8] !== exp_col || t_ecol[1] !== 1'b0) begin
            bad++;
            $display("FAIL colchk_flag: got done=%0b errcol=%0b/%0b want 1 %0b/0",
                     t_done[8], t_ecol[8], t_ecol[1], exp_col);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) vec_mem[i] = '0;
        for (int i = 0; i < 16; i++) nz_mem[i] = '0;
        basic_exp = '{{8'd0, 8'd0, 3'b001}, {8'd2, 8'd3, 3'b001}, {8'd5, 8'd0, 3'b001},
                      {8'hFF, 8'd1, 3'b001}, {8'd7, 8'd2, 3'b001}, {8'd3, 8'd0, 3'b101},
                      {8'hFE, 8'd2, 3'b001}, {8'd4, 8'd1, 3'b101}, {8'd0, 8'd0, 3'b010},
                      {8'd0, 8'd0, 3'b000}};
        test_reset();
        test_basic();
        test_nnz0();
        test_cfg_err();
        test_cols_max();
        test_zero_entry();
        test_restart_ignored();
        test_reset_mid();
        test_colchk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
